// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcode/funct/format encodings and the
// hazard controller state encoding.
package mips_pkg;

  localparam logic [5:0] OP_COP1    = 6'b010001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [4:0] FMT_S      = 5'h10;
  localparam logic [4:0] FMT_D      = 5'h11;
  localparam logic [5:0] FUNCT_FMUL = 6'h02;
  localparam logic [5:0] FUNCT_FDIV = 6'h03;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_FP_BUSY = 2'd1,
    HZ_LU_HOLD = 2'd2
  } hz_state_e;

endpackage

// File: rtl/fp_busy_counter.sv
// Occupancy counter for the unpipelined FP multiply/divide unit: loads the
// op latency on issue, counts down to zero and holds there.
module fp_busy_counter #(
  parameter int CNT_W      = 5,
  parameter int FP_MUL_LAT = 4,
  parameter int FP_DIV_LAT = 12
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(FP_MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(FP_DIV_LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? DIV_LAT : MUL_LAT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, branch
// and jump redirects, and structural stalls behind the multi-cycle FP unit.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int FP_MUL_LAT = 4,
  parameter int FP_DIV_LAT = 12,
  parameter int CNT_W      = 5,
  parameter int PERF_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [5:0]        Op_code,
  input  logic [5:0]        Funct_ID,
  input  logic [4:0]        Fmt,
  input  logic [4:0]        Rs_ID,
  input  logic [4:0]        Rt_ID,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_Rt,
  input  logic              Branch_Taken,
  input  logic              Jump_ID,
  output logic              PC_write,
  output logic              IF_stall,
  output logic              IF_Flush,
  output logic              ID_bubble,
  output logic              FP_busy,
  output logic [PERF_W-1:0] Stall_cycles
);

  logic      fp_op, long_op, lu, fp_hz, stall, fp_load, fp_busy_w;
  hz_state_e state_q, state_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  assign fp_op   = (Op_code == OP_COP1) && ((Fmt == FMT_S) || (Fmt == FMT_D));
  assign long_op = fp_op && ((Funct_ID == FUNCT_FMUL) || (Funct_ID == FUNCT_FDIV));
  assign lu      = EX_MemRead && (EX_Rt != 5'd0) && ((EX_Rt == Rs_ID) || (EX_Rt == Rt_ID));
  assign fp_hz   = fp_op && fp_busy_w;
  assign stall   = lu || fp_hz;
  // A wrong-path long op must not occupy the FP unit.
  assign fp_load = long_op && !Branch_Taken && !stall;

  fp_busy_counter #(
    .CNT_W     (CNT_W),
    .FP_MUL_LAT(FP_MUL_LAT),
    .FP_DIV_LAT(FP_DIV_LAT)
  ) u_fp_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .load  (fp_load),
    .is_div(Funct_ID == FUNCT_FDIV),
    .busy  (fp_busy_w)
  );

  always_comb begin
    PC_write  = 1'b1;
    IF_stall  = 1'b0;
    IF_Flush  = 1'b0;
    ID_bubble = 1'b0;
    if (Rst) begin
      PC_write  = 1'b0;
      IF_Flush  = 1'b1;
      ID_bubble = 1'b1;
    end else if (Branch_Taken) begin
      IF_Flush  = 1'b1;
      ID_bubble = 1'b1;
    end else if (stall) begin
      PC_write  = 1'b0;
      IF_stall  = 1'b1;
      ID_bubble = 1'b1;
    end else if (Jump_ID) begin
      IF_Flush  = 1'b1;
    end
  end

  assign FP_busy = Rst ? 1'b0 : fp_busy_w;

  // The stall pushes a bubble into EX, so the same load cannot re-trigger
  // from LU_HOLD; that state always falls back to RUN/FP_BUSY.
  always_comb begin
    state_d = (fp_load || fp_busy_w) ? HZ_FP_BUSY : HZ_RUN;
    case (state_q)
      HZ_LU_HOLD: ;
      default:    if (lu && !Branch_Taken) state_d = HZ_LU_HOLD;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= HZ_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: stimulus pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [5:0]  Op_code = '0;
  logic [5:0]  Funct_ID = '0;
  logic [4:0]  Fmt = '0;
  logic [4:0]  Rs_ID = '0;
  logic [4:0]  Rt_ID = '0;
  logic        EX_MemRead = 1'b0;
  logic [4:0]  EX_Rt = '0;
  logic        Branch_Taken = 1'b0;
  logic        Jump_ID = 1'b0;
  logic        PC_write, IF_stall, IF_Flush, ID_bubble, FP_busy;
  logic [15:0] Stall_cycles;

  pipeline_hazard_ctrl #(
    .FP_MUL_LAT(4), .FP_DIV_LAT(12), .CNT_W(5), .PERF_W(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Op_code(Op_code), .Funct_ID(Funct_ID), .Fmt(Fmt),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .Branch_Taken(Branch_Taken), .Jump_ID(Jump_ID), .PC_write(PC_write),
    .IF_stall(IF_stall), .IF_Flush(IF_Flush), .ID_bubble(ID_bubble),
    .FP_busy(FP_busy), .Stall_cycles(Stall_cycles)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [4:0]  flags;   // {PC_write, IF_stall, IF_Flush, ID_bubble, FP_busy}
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_sc = '0;

  // Expected flag patterns {PC_write, IF_stall, IF_Flush, ID_bubble, FP_busy}
  localparam logic [4:0] E_RST   = 5'b00110;
  localparam logic [4:0] E_RUN   = 5'b10000;
  localparam logic [4:0] E_RUNF  = 5'b10001;
  localparam logic [4:0] E_STL   = 5'b01010;
  localparam logic [4:0] E_STLF  = 5'b01011;
  localparam logic [4:0] E_BR    = 5'b10110;
  localparam logic [4:0] E_BRF   = 5'b10111;
  localparam logic [4:0] E_JMP   = 5'b10100;

  localparam logic [5:0] OPC = 6'b010001;
  localparam logic [5:0] ADDI = 6'b001000;

  task automatic step(input string nm, input logic r,
                      input logic [5:0] op, input logic [5:0] fn, input logic [4:0] fm,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] er,
                      input logic bt, input logic jp,
                      input logic [4:0] ef, input logic inc);
    exp_t e;
    @(posedge Clk);
    #1;
    Rst = r; Op_code = op; Funct_ID = fn; Fmt = fm; Rs_ID = rs; Rt_ID = rt;
    EX_MemRead = mr; EX_Rt = er; Branch_Taken = bt; Jump_ID = jp;
    if (r) exp_sc = '0;
    e.name = nm; e.flags = ef; e.sc = exp_sc;
    exp_q.push_back(e);
    if (inc && !r) exp_sc = exp_sc + 16'd1;
  endtask

  task automatic nop(input string nm, input logic [4:0] ef);
    step(nm, 0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, ef, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {PC_write, IF_stall, IF_Flush, ID_bubble, FP_busy};
        checks++;
        if (act !== e.flags || Stall_cycles !== e.sc) begin
          errors++;
          $display("FAIL %s: got flags=%b sc=%0d, want flags=%b sc=%0d",
                   e.name, act, Stall_cycles, e.flags, e.sc);
        end else begin
          $display("ok   %s: flags=%b sc=%0d", e.name, act, Stall_cycles);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    for (int i = 0; i < 3; i++) step("reset", 1, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, E_RST, 0);
    nop("idle0", E_RUN);
    nop("idle1", E_RUN);
    // Load-use on rs, then guarded EX_Rt=0, then load-use on rt
    step("lu_rs", 0, ADDI, 6'd0, 5'd0, 5'd8, 5'd1, 1, 5'd8, 0, 0, E_STL, 1);
    nop("after_lu", E_RUN);
    step("lu_r0", 0, ADDI, 6'd0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 0, 0, E_RUN, 0);
    step("lu_rt", 0, ADDI, 6'd0, 5'd0, 5'd3, 5'd9, 1, 5'd9, 0, 0, E_STL, 1);
    // div.s issue then add.s held behind the 12-cycle busy window
    step("div_issue", 0, OPC, 6'h03, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    for (int i = 0; i < 12; i++)
      step("adds_stall", 0, OPC, 6'h00, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_STLF, 1);
    step("adds_release", 0, OPC, 6'h00, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    // mul.d issue; integer work proceeds during the 4 busy cycles
    step("muld_issue", 0, OPC, 6'h02, 5'h11, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    for (int i = 0; i < 4; i++)
      step("addi_busy", 0, ADDI, 6'd0, 5'd0, 5'd4, 5'd5, 0, 5'd0, 0, 0, E_RUNF, 0);
    step("addi_free", 0, ADDI, 6'd0, 5'd0, 5'd4, 5'd5, 0, 5'd0, 0, 0, E_RUN, 0);
    // Branch beats load-use; wrong-path div.s must not start
    step("br_div_lu", 0, OPC, 6'h03, 5'h10, 5'd8, 5'd2, 1, 5'd8, 1, 0, E_BR, 1);
    nop("br_no_issue", E_RUN);
    // Branch does not clear a running FP op
    step("mul_issue", 0, OPC, 6'h02, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    step("br_busy", 0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 1, 0, E_BRF, 0);
    for (int i = 0; i < 3; i++) nop("busy_tail", E_RUNF);
    nop("busy_done", E_RUN);
    // Jump held by load-use, redirects next cycle
    step("jmp_lu", 0, 6'd2, 6'd0, 5'd0, 5'd8, 5'd0, 1, 5'd8, 0, 1, E_STL, 1);
    step("jmp_go", 0, 6'd2, 6'd0, 5'd0, 5'd8, 5'd0, 0, 5'd0, 0, 1, E_JMP, 0);
    // Back-to-back mul.s: second waits 4 cycles then issues
    step("mul_a", 0, OPC, 6'h02, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    for (int i = 0; i < 4; i++)
      step("mul_b_stall", 0, OPC, 6'h02, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_STLF, 1);
    step("mul_b_issue", 0, OPC, 6'h02, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    nop("mul_b_busy", E_RUNF);
    // Reset mid-busy clears immediately; add.s afterwards is not stalled
    step("rst_mid", 1, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, E_RST, 0);
    step("post_rst", 0, OPC, 6'h00, 5'h10, 5'd1, 5'd2, 0, 5'd0, 0, 0, E_RUN, 0);
    nop("final", E_RUN);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge Clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the IF/ID register's IF_stall and IF_Flush inputs, PC write enable, and the ID->EX control bubble.
- Sequences three hazard classes: load-use, taken branch/jump redirect, and structural stalls on the unpipelined multi-cycle FP unit (COP1 mul/div).
- Sits beside the ID stage and observes ID fields plus EX-stage status.

Parameters:
- FP_MUL_LAT, 4, busy cycles of mul.s/mul.d after issue (1..2^CNT_W-1)
- FP_DIV_LAT, 12, busy cycles of div.s/div.d after issue (1..2^CNT_W-1)
- CNT_W, 5, FP busy counter width
- PERF_W, 16, stall-cycle counter width

Ports:
- Clk  in  1  pipeline clock; state updates on posedge
- Rst  in  1  asynchronous, active-high reset
- Op_code  in  6  opcode of instruction in ID
- Funct_ID  in  6  funct field in ID
- Fmt  in  5  COP1 format field in ID
- Rs_ID  in  5  rs of instruction in ID
- Rt_ID  in  5  rt of instruction in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rt  in  5  destination rt of load in EX
- Branch_Taken  in  1  branch resolved taken in EX
- Jump_ID  in  1  jump/jal/jr decoded in ID
- PC_write  out  1  PC register enable
- IF_stall  out  1  hold IF/ID
- IF_Flush  out  1  zero IF/ID
- ID_bubble  out  1  zero ID->EX control signals
- FP_busy  out  1  FP unit occupied
- Stall_cycles  out  PERF_W  saturating count of stall cycles

Behaviour:
- One clock (Clk); reset asynchronous, active-high (Rst). State and counters are posedge registers. Outputs are combinational from state plus current inputs, so they are valid before the negedge at which IF/ID samples.
- While Rst=1: PC_write=0, IF_stall=0, IF_Flush=1, ID_bubble=1, FP_busy=0. Registers clear to state RUN, fp_cnt=0, Stall_cycles=0.
- Decode:
  - fp_op = (Op_code==6'b010001) and Fmt in {S=5'h10, D=5'h11}.
  - long_op = fp_op and Funct_ID in {MUL=6'h02, DIV=6'h03}.
- Hazard terms:
  - lu = EX_MemRead and EX_Rt!=0 and (EX_Rt==Rs_ID or EX_Rt==Rt_ID).
  - fp_hz = fp_op and fp_cnt!=0.
  - stall = lu or fp_hz.
- Output priority, highest first:
  - 1) Branch_Taken: IF_Flush=1, ID_bubble=1, PC_write=1, IF_stall=0. Any ID instruction is wrong-path; a long_op in ID is NOT started.
  - 2) stall: IF_stall=1, PC_write=0, ID_bubble=1, IF_Flush=0. Jump_ID is ignored while stalled; the jump stays in ID and redirects after release.
  - 3) Jump_ID: IF_Flush=1, PC_write=1, ID_bubble=0, IF_stall=0.
  - 4) none: PC_write=1, all others 0.
- States (2-bit):
  - RUN (fp_cnt==0).
  - FP_BUSY (fp_cnt!=0).
  - LU_HOLD: one cycle after a load-use stall. Used only for performance accounting; no output effect.
- FP counter:
  - Loaded on a posedge when long_op, no Branch_Taken and not stall. Load value is FP_MUL_LAT or FP_DIV_LAT per funct; the op issues that cycle.
  - Otherwise decrements to 0 and does not wrap. Branch_Taken does not clear a running counter, because the issued FP op is older than the branch.
  - Back-to-back long_op: the second op stalls until fp_cnt==0, then issues and reloads in the same cycle.
  - Non-FP instructions proceed while FP_BUSY.
- FP_busy = (fp_cnt!=0).
- Stall_cycles increments on each posedge with stall=1 and Rst=0, saturating at 2^PERF_W-1.
- Rst asserted mid-FP_BUSY: counter clears immediately, with no pending stall after release.

Decomposition:
- Shared package mips_pkg:
  - OP_COP1, FMT_S, FMT_D, FUNCT_FMUL, FUNCT_FDIV, OP_LW.
  - Hazard state encoding.
- Sub-module fp_busy_counter: load/decrement/zero-detect. Parameters CNT_W, FP_MUL_LAT, FP_DIV_LAT. Ports Clk, Rst, load, is_div, busy.

Test Plan:
- Reset held for 3 cycles then released, no hazards -> during Rst IF_Flush=1, ID_bubble=1, PC_write=0; after release PC_write=1, others 0, Stall_cycles=0.
- EX_MemRead=1, EX_Rt=5'd8, Rs_ID=5'd8 for one cycle -> IF_stall=1, PC_write=0, ID_bubble=1 that cycle; Stall_cycles=1. Repeat with EX_Rt=0 -> no stall.
- div.s in ID (Op 010001, Fmt 10000, Funct 000011), then add.s next cycle -> div issues, FP_busy=1 for 12 cycles; add.s stalled 12 cycles then released; Stall_cycles=12.
- mul.s issue, then non-FP addi in ID -> no stall, FP_busy high exactly 4 cycles.
- Branch_Taken=1 with div.s in ID and EX_MemRead hazard simultaneously -> IF_Flush=1, ID_bubble=1, PC_write=1, IF_stall=0; fp_cnt remains 0.
- Jump_ID=1 coincident with load-use hazard -> first cycle stall only (IF_Flush=0); next cycle IF_Flush=1, PC_write=1. Rst pulsed mid-FP_BUSY -> FP_busy=0 immediately.
